// File: rtl/gate_truth_checker.sv
// Stimulus/response checker for small combinational gate models: walks every input
// vector, holds it SETTLE cycles, compares the sampled output against EXP_TT.
// Optional build macro: GATE_CHK_STOP_ON_FAIL_EN ends the run at the first mismatch.
module gate_truth_checker #(
  parameter int                   N_IN   = 2,
  parameter int                   SETTLE = 2,
  parameter logic [2**N_IN-1:0]   EXP_TT = 4'b0111
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [N_IN-1:0]       dut_in,
  input  logic                  dut_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [N_IN:0]         err_count,
  output logic [2**N_IN-1:0]    fail_vec
);

  localparam int NV = 2**N_IN;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [N_IN-1:0] LAST_VEC = N_IN'(NV - 1);

`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_REPORT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N_IN-1:0]     dut_in_q, dut_in_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [N_IN:0]       err_q, err_d;
  logic [NV-1:0]       fail_q, fail_d;
  logic                mism_s;

  // Next-state and result update; X/Z on dut_out must count as a mismatch.
  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    fail_d   = fail_q;
    mism_s   = (dut_out !== EXP_TT[dut_in_q]);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          dut_in_d = '0;
          cnt_d    = CNT_LOAD;
          busy_d   = 1'b1;
          pass_d   = 1'b0;
          err_d    = '0;
          fail_d   = '0;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_RUN: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (mism_s) begin
            err_d            = err_q + (N_IN+1)'(1);
            fail_d[dut_in_q] = 1'b1;
          end else begin
            err_d            = err_q;
          end

          if (STOP_ON_FAIL && mism_s) begin
            // Leave dut_in on the failing vector for debug.
            state_d = S_REPORT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
          end else if (dut_in_q != LAST_VEC) begin
            dut_in_d = dut_in_q + N_IN'(1);
            cnt_d    = CNT_LOAD;
          end else begin
            state_d = S_REPORT;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end

      S_REPORT: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      dut_in_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
    end
  end

  assign dut_in    = dut_in_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Scoreboard bench for gate_truth_checker: a configurable gate model is checked
// against expectations derived from the truth-table mismatch mask.
module tb_gate_truth_checker;

  localparam int         N_IN   = 2;
  localparam int         SETTLE = 2;
  localparam int         NV     = 4;
  localparam logic [3:0] EXP_TT = 4'b0111;
`ifdef GATE_CHK_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] dut_in;
  logic       dut_out;
  logic       busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  logic       start2 = 1'b0;
  logic [0:0] dut2_in;
  logic       dut2_out;
  logic       busy2, done2, pass2;
  logic [1:0] err2, fail2;

  logic [3:0] gut_tt = 4'b0111;
  bit         gut_z2 = 1'b0;

  always #5 clk = ~clk;

  gate_truth_checker #(.N_IN(N_IN), .SETTLE(SETTLE), .EXP_TT(EXP_TT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dut_in(dut_in), .dut_out(dut_out),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .fail_vec(fail_vec)
  );

  gate_truth_checker #(.N_IN(1), .SETTLE(1), .EXP_TT(2'b01)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .dut_in(dut2_in), .dut_out(dut2_out),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2)
  );

  // Gate under test: truth table gut_tt, optionally floating for vector 2.
  always_comb begin
    if (gut_z2 && dut_in == 2'd2) dut_out = 1'bz;
    else                          dut_out = gut_tt[dut_in];
  end
  assign dut2_out = ~dut2_in[0];

  typedef struct {
    bit         pass;
    int         err;
    logic [3:0] fail;
    int         last;
    int         lat;
    int         acc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: mismatch mask = observed table XOR expected table; Z is always wrong.
  function automatic exp_t model(input logic [3:0] tt, input bit z2, input int acc);
    exp_t e;
    logic [3:0] m;
    int first;
    first = -1;
    m = tt ^ EXP_TT;
    if (z2) m[2] = 1'b1;
    for (int i = 0; i < NV; i++) if (m[i] && first < 0) first = i;
    if (STOP && first >= 0) begin
      m = 4'b0000;
      m[first] = 1'b1;
      e.last = first;
      e.lat  = (first + 1) * SETTLE;
    end else begin
      e.last = NV - 1;
      e.lat  = NV * SETTLE;
    end
    e.fail = m;
    e.err  = $countones(m);
    e.pass = (m == 4'b0000);
    e.acc  = acc;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done: got done=1 expected no pending run (t=%0t)", $time);
      end else begin
        mon_e = sb_q.pop_front();
        chk("pass", int'(pass), int'(mon_e.pass));
        chk("err_count", int'(err_count), mon_e.err);
        chk("fail_vec", int'(fail_vec), int'(mon_e.fail));
        chk("dut_in_at_done", int'(dut_in), mon_e.last);
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", name);
      sb_q.delete();
    end else begin
      @(negedge clk);
      chk("done_one_cycle", int'(done), 0);
      chk("busy_after_done", int'(busy), 0);
    end
  endtask

  task automatic run(input logic [3:0] tt, input bit z2, input bit poke);
    @(negedge clk);
    gut_tt = tt;
    gut_z2 = z2;
    sb_q.push_back(model(tt, z2, cyc + 1));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    if (poke) begin
      @(negedge clk);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done("run");
    if (poke) begin
      repeat (3) @(negedge clk);
      chk("no_second_run", int'(busy), 0);
    end
  endtask

  task automatic chk_reset_vals(input string name);
    chk({name, "_dut_in"}, int'(dut_in), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_done"}, int'(done), 0);
    chk({name, "_pass"}, int'(pass), 0);
    chk({name, "_err"}, int'(err_count), 0);
    chk({name, "_fail"}, int'(fail_vec), 0);
  endtask

  initial begin
    int n;
    int acc;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    run(4'b0111, 1'b0, 1'b0);   // correct NAND
    run(4'b1000, 1'b0, 1'b0);   // AND
    run(4'b1111, 1'b0, 1'b0);   // stuck at 1
    run(4'b0111, 1'b1, 1'b0);   // floating on vector 2
    run(4'b0111, 1'b0, 1'b1);   // start re-pulsed mid-run

    // Abort mid-run with reset between E4 and E5.
    @(negedge clk);
    gut_tt = 4'b0111;
    gut_z2 = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("abort");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("abort_no_done", int'(done), 0);
    run(4'b0111, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run(4'($urandom_range(0, 15)), bit'($urandom_range(0, 1)), 1'b0);
    end

    // Single-input inverter with SETTLE=1.
    @(negedge clk);
    start2 = 1'b1;
    acc = cyc + 1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (!done2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("inv_done_seen", int'(done2), 1);
    chk("inv_latency", cyc - acc, 2);
    chk("inv_pass", int'(pass2), 1);
    chk("inv_err", int'(err2), 0);
    chk("inv_fail", int'(fail2), 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
